traffic_light_fsm: RTL and testbench

//  Two-way (NS/EW) traffic-light sequencer on the fast system clock clk100.

---
 rtl/traffic_pkg.sv | 77 +++++++
 rtl/tick_edge_sync.sv | 40 ++++
 rtl/traffic_light_fsm.sv | 122 ++++++++++++
 tb/tb_traffic_light_fsm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the two-way traffic-light sequencer.
//   phase_e     : 3-bit phase encoding; codes 6 and 7 are unused and treated as illegal.
//   RED/YEL/GRN : one-hot lamp codes, bit order {red,yellow,green}.
//   phase_dur   : maps a phase to its duration in ticks, given the duration parameters.
//   next_phase  : fixed phase rotation.
//   ns_code/ew_code : lamp vectors displayed in each phase.
//   is_green/is_yellow : phase class tests used by the timer and ped logic.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } phase_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  function automatic int unsigned phase_dur(input phase_e p,
                                            input int unsigned green_s,
                                            input int unsigned yellow_s,
                                            input int unsigned allred_s);
    int unsigned d;
    case (p)
      NS_GREEN, EW_GREEN:   d = green_s;
      NS_YELLOW, EW_YELLOW: d = yellow_s;
      default:              d = allred_s;
    endcase
    return d;
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      ALLRED_A:  n = NS_GREEN;
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALLRED_B;
      ALLRED_B:  n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      default:   n = ALLRED_A;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] ns_code(input phase_e p);
    logic [2:0] c;
    case (p)
      NS_GREEN:  c = GRN;
      NS_YELLOW: c = YEL;
      default:   c = RED;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] ew_code(input phase_e p);
    logic [2:0] c;
    case (p)
      EW_GREEN:  c = GRN;
      EW_YELLOW: c = YEL;
      default:   c = RED;
    endcase
    return c;
  endfunction

  function automatic logic is_green(input phase_e p);
    return (p == NS_GREEN) || (p == EW_GREEN);
  endfunction

  function automatic logic is_yellow(input phase_e p);
    return (p == NS_YELLOW) || (p == EW_YELLOW);
  endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Brings a slow, asynchronous clock-like signal into the clk100 domain and turns each
// rising edge into a single-cycle pulse.
//   clk100    in  system clock
//   reset     in  asynchronous, active-low reset
//   async_in  in  signal asynchronous to clk100
//   pulse_out out one clk100 cycle high per rising edge of async_in
// Two synchroniser flops then an edge register; the pulse is high in the cycle after the
// second synchroniser flop first captures a 1, so consumers see it act on the 3rd edge.
module tick_edge_sync (
  input  logic clk100,
  input  logic reset,
  input  logic async_in,
  output logic pulse_out
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign pulse_out = sync2_q & ~prev_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-way (NS/EW) traffic-light sequencer stepped by a slow tick.
//   clk100       in  system clock, all state on the rising edge
//   reset        in  asynchronous, active-low reset
//   tick_in      in  divided slow clock; each rising edge is one tick
//   ped_req      in  pedestrian button, level or pulse, sampled every clk100
//   ns_light     out {red,yellow,green} for the NS approach, one-hot, registered
//   ew_light     out {red,yellow,green} for the EW approach, one-hot, registered
//   sec_left     out ticks remaining in the current phase minus 1 (the timer register)
//   ped_served   out one-cycle pulse when a pending ped request shortens a green
//   state_dbg    out current phase register, for observation only
//   ped_pend_dbg out pending-ped latch, for observation only
// Phase rotation: ALLRED_A, NS_GREEN, NS_YELLOW, ALLRED_B, EW_GREEN, EW_YELLOW.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_S  = 5,
  parameter int unsigned YELLOW_S = 2,
  parameter int unsigned ALLRED_S = 1,
  parameter int unsigned SHORT_S  = 2,
  parameter int unsigned TW       = 8
) (
  input  logic          clk100,
  input  logic          reset,
  input  logic          tick_in,
  input  logic          ped_req,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic [TW-1:0] sec_left,
  output logic          ped_served,
  output phase_e        state_dbg,
  output logic          ped_pend_dbg
);

  localparam logic [TW-1:0] SHORT_M1  = TW'(SHORT_S - 1);
  localparam logic [TW-1:0] ALLRED_M1 = TW'(ALLRED_S - 1);
  localparam logic [TW-1:0] ONE       = TW'(1);

  function automatic logic [TW-1:0] dur_m1(input phase_e p);
    return TW'(phase_dur(p, GREEN_S, YELLOW_S, ALLRED_S) - 1);
  endfunction

  logic tick;

  tick_edge_sync u_tick_sync (
    .clk100    (clk100),
    .reset     (reset),
    .async_in  (tick_in),
    .pulse_out (tick)
  );

  phase_e        phase_q,    phase_d;
  logic [TW-1:0] timer_q,    timer_d;
  logic          ped_pend_q, ped_pend_d;
  logic [2:0]    ns_q,       ns_d;
  logic [2:0]    ew_q,       ew_d;
  logic          served_q,   served_d;

  always_comb begin
    phase_d    = phase_q;
    timer_d    = timer_q;
    // A request always sets the latch; the yellow-exit clear below re-applies ped_req
    // so a same-cycle request still wins over the clear.
    ped_pend_d = ped_pend_q | ped_req;
    served_d   = 1'b0;

    case (phase_q)
      ALLRED_A, NS_GREEN, NS_YELLOW, ALLRED_B, EW_GREEN, EW_YELLOW: begin
        if (tick) begin
          if (timer_q == '0) begin
            phase_d = next_phase(phase_q);
            timer_d = dur_m1(phase_d);
            if (is_yellow(phase_q)) begin
              ped_pend_d = ped_req;
            end
          end else if (is_green(phase_q) && ped_pend_q && (timer_q > SHORT_M1)) begin
            // Clamp: leave only SHORT_S ticks of green (counting this one as spent
            // is not done; the loaded value is SHORT_S-1 like a fresh phase).
            timer_d  = SHORT_M1;
            served_d = 1'b1;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
      end
      default: begin
        // Unused encodings recover to the reset phase without waiting for a tick.
        phase_d = ALLRED_A;
        timer_d = ALLRED_M1;
      end
    endcase

    // Lamps are decoded from the next phase so they change on the same edge as the state.
    ns_d = ns_code(phase_d);
    ew_d = ew_code(phase_d);
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      phase_q    <= ALLRED_A;
      timer_q    <= ALLRED_M1;
      ped_pend_q <= 1'b0;
      ns_q       <= RED;
      ew_q       <= RED;
      served_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
      served_q   <= served_d;
    end
  end

  assign ns_light     = ns_q;
  assign ew_light     = ew_q;
  assign sec_left     = timer_q;
  assign ped_served   = served_q;
  assign state_dbg    = phase_q;
  assign ped_pend_dbg = ped_pend_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  localparam int TW = 8;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  // ---------------- clock / reset ----------------
  logic clk100  = 1'b0;
  logic reset   = 1'b0;
  logic tick_in = 1'b0;
  logic ped_req = 1'b0;

  logic [2:0]    ns_light, ew_light;
  logic [TW-1:0] sec_left;
  logic          ped_served;
  phase_e        state_dbg;
  logic          ped_pend_dbg;

  always #5 clk100 = ~clk100;

  traffic_light_fsm #(
    .GREEN_S (5),
    .YELLOW_S(2),
    .ALLRED_S(1),
    .SHORT_S (2),
    .TW      (TW)
  ) dut (
    .clk100      (clk100),
    .reset       (reset),
    .tick_in     (tick_in),
    .ped_req     (ped_req),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .sec_left    (sec_left),
    .ped_served  (ped_served),
    .state_dbg   (state_dbg),
    .ped_pend_dbg(ped_pend_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int served_cnt = 0;
  logic [TW-1:0] exp_q[$];

  always @(posedge clk100) begin
    if (ped_served === 1'b1) served_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            mode;   // 0 none, 1 ped pulse before the tick, 2 ped on the tick cycle
    phase_e        ph;
    logic [2:0]    ns;
    logic [2:0]    ew;
    logic [TW-1:0] sec;
    logic          srv;
    logic          pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int mode, input phase_e ph, input logic [2:0] ns,
                              input logic [2:0] ew, input logic [TW-1:0] sec,
                              input logic srv, input logic pend);
    vec_t v;
    v.mode = mode; v.ph = ph; v.ns = ns; v.ew = ew; v.sec = sec; v.srv = srv; v.pend = pend;
    vecs.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_phase"}, state_dbg, ALLRED_A);
    check({tag, "_ns"}, ns_light, R);
    check({tag, "_ew"}, ew_light, R);
    check({tag, "_sec"}, sec_left, 0);
    check({tag, "_served"}, ped_served, 0);
    check({tag, "_pend"}, ped_pend_dbg, 0);
  endtask

  task automatic do_reset();
    @(negedge clk100);
    reset = 1'b0; tick_in = 1'b0; ped_req = 1'b0;
    repeat (3) @(negedge clk100);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk100);
  endtask

  // One tick: rise at a negedge, pulse lives between the 2nd and 3rd posedge.
  task automatic tick(input int mode);
    if (mode == 1) begin
      @(negedge clk100); ped_req = 1'b1;
      @(negedge clk100); ped_req = 1'b0;
    end
    @(negedge clk100); tick_in = 1'b1;
    @(negedge clk100);
    @(negedge clk100); tick_in = 1'b0;
    if (mode == 2) ped_req = 1'b1;
    @(negedge clk100); ped_req = 1'b0;
    repeat (3) @(negedge clk100);
  endtask

  task automatic run_vecs(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      int c0;
      c0 = served_cnt;
      tick(vecs[i].mode);
      check($sformatf("%s_v%0d_phase", tag, i), state_dbg, vecs[i].ph);
      check($sformatf("%s_v%0d_ns", tag, i), ns_light, vecs[i].ns);
      check($sformatf("%s_v%0d_ew", tag, i), ew_light, vecs[i].ew);
      check($sformatf("%s_v%0d_sec", tag, i), sec_left, vecs[i].sec);
      check($sformatf("%s_v%0d_served", tag, i), served_cnt - c0, vecs[i].srv);
      check($sformatf("%s_v%0d_pend", tag, i), ped_pend_dbg, vecs[i].pend);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Plain sequence from reset.
    add(0, NS_GREEN,  G, R, 4, 0, 0);  // 0
    add(0, NS_GREEN,  G, R, 3, 0, 0);
    add(0, NS_GREEN,  G, R, 2, 0, 0);
    add(0, NS_GREEN,  G, R, 1, 0, 0);
    add(0, NS_GREEN,  G, R, 0, 0, 0);
    add(0, NS_YELLOW, Y, R, 1, 0, 0);  // 5
    add(0, NS_YELLOW, Y, R, 0, 0, 0);
    add(0, ALLRED_B,  R, R, 0, 0, 0);
    add(0, EW_GREEN,  R, G, 4, 0, 0);
    add(0, EW_GREEN,  R, G, 3, 0, 0);
    add(0, EW_GREEN,  R, G, 2, 0, 0);  // 10
    add(0, EW_GREEN,  R, G, 1, 0, 0);
    add(0, EW_GREEN,  R, G, 0, 0, 0);
    add(0, EW_YELLOW, R, Y, 1, 0, 0);
    add(0, EW_YELLOW, R, Y, 0, 0, 0);
    add(0, ALLRED_A,  R, R, 0, 0, 0);  // 15
    add(0, NS_GREEN,  G, R, 4, 0, 0);
    // Ped at green entry: clamp 4 -> 1.
    add(1, NS_GREEN,  G, R, 1, 1, 1);
    add(0, NS_GREEN,  G, R, 0, 0, 1);
    add(0, NS_YELLOW, Y, R, 1, 0, 1);
    add(0, NS_YELLOW, Y, R, 0, 0, 1);  // 20
    add(0, ALLRED_B,  R, R, 0, 0, 0);
    add(0, EW_GREEN,  R, G, 4, 0, 0);
    add(0, EW_GREEN,  R, G, 3, 0, 0);
    add(0, EW_GREEN,  R, G, 2, 0, 0);
    add(0, EW_GREEN,  R, G, 1, 0, 0);  // 25
    add(0, EW_GREEN,  R, G, 0, 0, 0);
    add(0, EW_YELLOW, R, Y, 1, 0, 0);
    add(0, EW_YELLOW, R, Y, 0, 0, 0);
    add(0, ALLRED_A,  R, R, 0, 0, 0);
    add(0, NS_GREEN,  G, R, 4, 0, 0);  // 30
    add(0, NS_GREEN,  G, R, 3, 0, 0);
    add(0, NS_GREEN,  G, R, 2, 0, 0);
    add(0, NS_GREEN,  G, R, 1, 0, 0);
    // Ped with timer=1: no clamp, latch set, normal decrement.
    add(1, NS_GREEN,  G, R, 0, 0, 1);
    add(0, NS_YELLOW, Y, R, 1, 0, 1);  // 35
    add(0, NS_YELLOW, Y, R, 0, 0, 1);
    // Ped on the yellow-exit tick keeps the latch.
    add(2, ALLRED_B,  R, R, 0, 0, 1);
    add(0, EW_GREEN,  R, G, 4, 0, 1);
    add(0, EW_GREEN,  R, G, 1, 1, 1);
    add(0, EW_GREEN,  R, G, 0, 0, 1);  // 40
    add(0, EW_YELLOW, R, Y, 1, 0, 1);
    add(0, EW_YELLOW, R, Y, 0, 0, 1);
    add(0, ALLRED_A,  R, R, 0, 0, 0);

    // Full table run from reset.
    do_reset();
    run_vecs(0, vecs.size() - 1, "seq");

    // Tick latency: change on the 3rd edge only; a long high level is one tick.
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(4);
    @(negedge clk100); tick_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk100);
      check($sformatf("lat_edge%0d_sec", k), sec_left, exp_q.pop_front());
      check($sformatf("lat_edge%0d_phase", k), state_dbg, (k == 3) ? NS_GREEN : ALLRED_A);
    end
    repeat (37) @(negedge clk100);
    check("hold_sec", sec_left, 4);
    check("hold_phase", state_dbg, NS_GREEN);
    tick_in = 1'b0;
    repeat (4) @(negedge clk100);
    check("hold_release_sec", sec_left, 4);

    // Asynchronous reset mid EW_YELLOW, then restart sequence.
    do_reset();
    run_vecs(0, 13, "pre_rst");
    @(posedge clk100);
    #3 reset = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(negedge clk100);
    reset = 1'b1;
    @(negedge clk100);
    run_vecs(0, 11, "restart");

    // Random ticks and ped requests: lamp safety and one-cycle served pulse.
    do_reset();
    begin
      logic prev_served;
      prev_served = 1'b0;
      for (int c = 0; c < 20000; c++) begin
        @(negedge clk100);
        check("rand_ns_onehot", $onehot(ns_light), 1);
        check("rand_ew_onehot", $onehot(ew_light), 1);
        check("rand_one_red", (ns_light == R) || (ew_light == R), 1);
        check("rand_served_width", prev_served & ped_served, 0);
        prev_served = ped_served;
        tick_in = 1'(($urandom_range(0, 1)));
        ped_req = ($urandom_range(0, 15) == 0);
      end
    end
    tick_in = 1'b0;
    ped_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
